// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the streaming instruction-memory loader and its
//   consumers (Instruction_Memory and the loader bench).
//   - loader_state_t : loader session state
//   - IMEM_DEPTH     : default instruction-memory depth in words
//   - IMEM_WORD_W    : default instruction width in bits
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage : imem_loader_pkg

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Hardware preload path for the single-cycle CPU instruction memory.
//   A go_i pulse starts a session: every word is zero-filled, then a
//   valid/ready instruction stream is written from address 0 upward. A clean
//   session ends with cpu_start_o held high so it can drive the CPU start_i.
//
// Ports
//   clk_i          : clock
//   rst_i          : asynchronous active-low reset
//   go_i           : single-cycle session request (honoured in IDLE / DONE)
//   load_valid_i   : stream word valid
//   load_data_i    : stream instruction word
//   load_last_i    : final word of the stream (qualified by valid)
//   load_ready_o   : loader accepts a word this cycle (decoded from state)
//   imem_we_o      : instruction-memory write enable (registered)
//   imem_addr_o    : instruction-memory word address (registered)
//   imem_wdata_o   : instruction-memory write data (registered)
//   busy_o         : session in CLEAR or LOAD
//   cpu_start_o    : memory complete and no overflow; CPU may run
//   err_o          : sticky overflow flag for the current session
//   word_count_o   : words accepted this session, saturating at DEPTH
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 8,
    parameter int WORD_W = IMEM_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic              load_valid_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [WORD_W-1:0] imem_wdata_o,
    output logic              busy_o,
    output logic              cpu_start_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;        // next address to write
    logic [ADDR_W:0]   count_q, count_d;      // words accepted this session
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;

    logic              handshake;
    logic              room;

    assign load_ready_o = (state_q == LOAD);
    assign handshake    = load_ready_o && load_valid_i;

    // Writes are gated by the accepted-word count, not by the address: the
    // address counter wraps to 0 after DEPTH words and must not overwrite
    // the start of the program.
    assign room         = (count_q < FULL_CNT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (go_i) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end

            CLEAR: begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = '0;
                addr_d  = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end

            LOAD: begin
                if (handshake) begin
                    if (room) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = load_data_i;
                        addr_d  = addr_q + 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        // Overflow words are drained so the host never
                        // stalls, but they are dropped and flagged.
                        err_d = 1'b1;
                    end
                    if (load_last_i) begin
                        state_d = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == CLEAR) || (state_d == LOAD);

        // Decoded from the current state rather than the next one so that
        // start rises a full cycle after the final write is presented; the
        // memory has committed that write before the CPU's first fetch.
        // A go_i in DONE drops start on the following cycle.
        start_d = (state_q == DONE) && !go_i && !err_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = busy_q;
    assign cpu_start_o  = start_q;
    assign err_o        = err_q;
    assign word_count_o = count_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Expected writes and the final memory
//   image come from a session-level model: after a session the memory holds
//   the first DEPTH stream words and zero everywhere else, the count is
//   min(words, DEPTH), and the error flag is set when words exceed DEPTH.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH  = IMEM_DEPTH;
    localparam int ADDR_W = 8;
    localparam int WORD_W = IMEM_WORD_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              go_i;
    logic              load_valid_i;
    logic [WORD_W-1:0] load_data_i;
    logic              load_last_i;
    logic              load_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [WORD_W-1:0] imem_wdata_o;
    logic              busy_o;
    logic              cpu_start_o;
    logic              err_o;
    logic [ADDR_W:0]   word_count_o;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .go_i         (go_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_last_i  (load_last_i),
        .load_ready_o (load_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .busy_o       (busy_o),
        .cpu_start_o  (cpu_start_o),
        .err_o        (err_o),
        .word_count_o (word_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
    } wr_t;

    wr_t               exp_q[$];
    logic [WORD_W-1:0] exp_mem [DEPTH];
    logic [WORD_W-1:0] dut_mem [DEPTH];
    int                n_chk = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every presented write must be the next one the model expects.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && imem_we_o === 1'b1) begin
            dut_mem[imem_addr_o] = imem_wdata_o;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(imem_addr_o), 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(imem_addr_o), 64'(e.a));
                chk("wr_data", 64'(imem_wdata_o), 64'(e.d));
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk(tag, {45'd0, imem_we_o, imem_addr_o, busy_o, cpu_start_o, err_o,
                  word_count_o, load_ready_o}, 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata_o), 64'd0);
    endtask

    task automatic pulse_go();
        @(negedge clk_i);
        go_i = 1'b1;
        @(posedge clk_i);
        #1 go_i = 1'b0;
    endtask

    // One session: go, clear sweep, n-word stream (last on word n).
    // mode 1 sends the fixed 3-word program with 1-cycle valid gaps.
    task automatic run_session(input int n, input int mode, input bit go_mid,
                               input int abort_after);
        logic [WORD_W-1:0] fixed3 [3];
        logic [WORD_W-1:0] w;
        int                gap;
        int                acc;
        int                to;
        fixed3[0] = 32'h0050_0093;
        fixed3[1] = 32'h00A0_0113;
        fixed3[2] = 32'h0020_81B3;
        acc = 0;

        pulse_go();
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back('{a: ADDR_W'(k), d: '0});
            exp_mem[k] = '0;
        end
        @(negedge clk_i);
        chk("go_busy", 64'(busy_o), 64'd1);
        chk("go_start_low", 64'(cpu_start_o), 64'd0);
        chk("go_err_clr", 64'(err_o), 64'd0);
        chk("go_cnt_clr", 64'(word_count_o), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk_i);
            chk("clr_we", 64'(imem_we_o), 64'd1);
            if (k < DEPTH - 1) chk("clr_ready", 64'(load_ready_o), 64'd0);
            if (k < DEPTH - 1) chk("clr_busy", 64'(busy_o), 64'd1);
        end
        chk("clr_to_load_ready", 64'(load_ready_o), 64'd1);

        for (int i = 0; i < n; i++) begin
            if (mode == 1) begin
                w   = fixed3[i];
                gap = (i == 0) ? 0 : 1;
            end else begin
                w   = $urandom;
                gap = $urandom_range(0, 2);
            end
            if (go_mid && i == 1 && gap == 0) gap = 1;
            load_valid_i = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (go_mid && i == 1 && g == 0) go_i = 1'b1;
                @(negedge clk_i);
                go_i = 1'b0;
            end
            load_valid_i = 1'b1;
            load_data_i  = w;
            load_last_i  = (i == n - 1);
            to = 0;
            while (!load_ready_o && to < 1000) begin
                @(negedge clk_i);
                to++;
            end
            if (to >= 1000) chk("ready_timeout", 64'd0, 64'd1);
            @(posedge clk_i);
            #1;
            load_valid_i = 1'b0;
            load_last_i  = 1'b0;
            if (acc < DEPTH) begin
                exp_q.push_back('{a: acc[ADDR_W-1:0], d: w});
                exp_mem[acc] = w;
            end
            @(negedge clk_i);
            chk("hs_we", 64'(imem_we_o), 64'(acc < DEPTH));
            acc++;
            if (abort_after == acc) return;
        end

        chk("last_busy", 64'(busy_o), 64'd0);
        chk("last_start_early", 64'(cpu_start_o), 64'd0);
        @(negedge clk_i);
        chk("done_start", 64'(cpu_start_o), 64'(n <= DEPTH));
        chk("done_err", 64'(err_o), 64'(n > DEPTH));
        chk("done_cnt", 64'(word_count_o), 64'((n < DEPTH) ? n : DEPTH));
        chk("done_ready", 64'(load_ready_o), 64'd0);
        chk("done_pending_wr", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("mem[%0d]", k), 64'(dut_mem[k]), 64'(exp_mem[k]));
        end
        // start is held steady in DONE
        repeat (3) @(negedge clk_i);
        chk("done_start_hold", 64'(cpu_start_o), 64'(n <= DEPTH));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b0;
        go_i         = 1'b0;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        load_last_i  = 1'b0;
        for (int k = 0; k < DEPTH; k++) dut_mem[k] = 'x;

        repeat (3) @(negedge clk_i);
        chk_reset_outs("rst_outs");
        rst_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            chk_reset_outs("idle_outs");
        end

        run_session(3, 1, 1'b0, 0);     // fixed program, clean start
        run_session(1, 0, 1'b0, 0);     // 1-word program, re-go from DONE
        run_session(258, 0, 1'b0, 0);   // overflow: two words dropped
        run_session(12, 0, 1'b1, 0);    // go ignored during LOAD

        // Reset in the middle of a load
        run_session(20, 0, 1'b0, 5);
        #2 rst_i = 1'b0;
        #1 chk_reset_outs("async_rst_outs");
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        chk_reset_outs("held_rst_outs");
        rst_i = 1'b1;
        run_session(4, 0, 1'b0, 0);

        for (int s = 0; s < 3; s++) begin
            run_session($urandom_range(1, 40), 0, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
# imem_loader

Streaming instruction-memory loader for the single-cycle CPU. It replaces the file-based memory preload with a hardware path. On a `go_i` request it zero-fills every instruction-memory word, then writes a valid/ready stream of 32-bit instructions from address 0 upward. When a clean load finishes, it raises `cpu_start_o` so the CPU `start_i` input can be driven from it. It sits between an external host/debug stream and the write port of `Instruction_Memory`, and is the writer counterpart to the bench-side memory/register readers.

## Interface
Parameters:
- `DEPTH`, 256: instruction-memory words; must be a power of two.
- `ADDR_W`, 8: word-address width, equal to log2(DEPTH).
- `WORD_W`, 32: instruction width.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `go_i`, in, 1: single-cycle request to start a load session.
- `load_valid_i`, in, 1: stream word valid.
- `load_data_i`, in, `WORD_W`: instruction word.
- `load_last_i`, in, 1: marks the final word of the stream; qualified by valid.
- `load_ready_o`, out, 1: the loader accepts a word this cycle.
- `imem_we_o`, out, 1: instruction-memory write enable.
- `imem_addr_o`, out, `ADDR_W`: word address.
- `imem_wdata_o`, out, `WORD_W`: write data.
- `busy_o`, out, 1: high in CLEAR or LOAD.
- `cpu_start_o`, out, 1: CPU start; high only in DONE with no error.
- `err_o`, out, 1: sticky overflow flag for the current session.
- `word_count_o`, out, `ADDR_W`+1: number of words accepted this session (0..DEPTH).

## Operation
- States: IDLE, CLEAR, LOAD, DONE.
- **IDLE**
  - Stays here until `go_i`=1, then moves to CLEAR.
  - On entry to CLEAR: address counter←0, `word_count_o`←0, `err_o`←0.
- **CLEAR**
  - Writes 0 to address 0, 1, …, DEPTH-1, one word per cycle.
  - After the write to DEPTH-1, moves to LOAD with address counter←0.
  - `load_ready_o`=0 throughout.
- **LOAD**
  - `load_ready_o`=1.
  - A handshake (valid & ready) writes `load_data_i` to the current address, then increments the address and `word_count_o`.
  - Once `word_count_o`==DEPTH, further handshakes are still accepted and drained, but no write occurs, `err_o`←1, and the count saturates at DEPTH.
  - A handshake with `load_last_i`=1 moves to DONE after that word is processed.
- **DONE**
  - `cpu_start_o`=~`err_o`, held steady.
  - `go_i`=1 starts a new session: `cpu_start_o` drops and the state moves to CLEAR.
- `go_i` is ignored in CLEAR and LOAD.
- The address counter is `ADDR_W` bits and wraps naturally. Writes are gated by the count, never by the wrapped address.

## Timing
- All outputs are registered except `load_ready_o`, which is decoded from state.
- Reset values: state IDLE; `imem_we_o`=0, `imem_addr_o`=0, `imem_wdata_o`=0, `busy_o`=0, `cpu_start_o`=0, `err_o`=0, `word_count_o`=0, `load_ready_o`=0.
- Write latency: the write for a handshake in cycle N appears on `imem_we_o`/`imem_addr_o`/`imem_wdata_o` in cycle N+1 and is committed at the end of N+1.
- CLEAR takes exactly DEPTH cycles. The first handshake can occur in the cycle after the last clear write is launched.
- `cpu_start_o` rises one cycle after the last write is presented, so memory is complete before the CPU's first fetch.
- `load_last_i` on the very first word gives a 1-word program, and DONE follows one cycle later.
- Valid held low in LOAD means the loader waits indefinitely. There is no timeout.
- Reset asserted mid-session returns everything to reset values immediately. A partially written memory is not restored; the next session's CLEAR handles it.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum `loader_state_t` (IDLE/CLEAR/LOAD/DONE);
  - default constants `IMEM_DEPTH`=256 and `IMEM_WORD_W`=32, also used by `Instruction_Memory` and the bench.
- Single module. The address/count logic is small enough to stay inline, so no sub-module.

## Test plan
- **Reset/idle:** release `rst_i` with `go_i`=0 for 10 cycles → all outputs stay 0; `imem_we_o` is never asserted.
- **Clear sweep:** pulse `go_i` → exactly 256 writes of 0 to addresses 0..255 in consecutive cycles, with `busy_o`=1 and `load_ready_o`=0.
- **3-word load:** after CLEAR, send 0x00500093, 0x00A00113, 0x002081B3 (last on the third) with a 1-cycle valid gap → writes land at addresses 0,1,2; `word_count_o`=3; `cpu_start_o`=1 one cycle after the third write.
- **Overflow:** send 258 words, last on #258 → addresses 0..255 written, words 257–258 dropped, `err_o`=1, `word_count_o`=256, `cpu_start_o`=0.
- **Reset mid-load:** drop `rst_i` after 5 loaded words → outputs return to reset values asynchronously. A following `go_i` runs a full CLEAR again.
- **Re-go from DONE:** `go_i` in DONE → `cpu_start_o` falls next cycle and CLEAR restarts. A `go_i` pulse during LOAD is ignored, and the session completes normally.
